// File: rtl/vga_mem_read_arbiter.sv
// vga_mem_read_arbiter
//   Shares one pipelined Avalon-MM read port between two read masters.
//   Master 0 is the VGA frame buffer stream and has priority. Master 1 is a secondary
//   reader. Master 1 is guaranteed a slot after STARVE_LIMIT consecutive m0 accepts.
//   A tag FIFO remembers which master issued each outstanding read so responses are
//   routed back in issue order.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   m0_* / m1_*                 read, address, byteenable in; readdata, waitrequest,
//                               readdatavalid out (readdata is shared by both masters)
//   s_read/s_address/s_byteenable   request to memory
//   s_readdata/s_waitrequest/s_readdatavalid   response and stall from memory
module vga_mem_read_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MAX_PENDING  = 8,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m0_read,
   input  logic [ADDR_WIDTH-1:0]   m0_address,
   input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
   output logic [DATA_WIDTH-1:0]   m0_readdata,
   output logic                    m0_waitrequest,
   output logic                    m0_readdatavalid,
   input  logic                    m1_read,
   input  logic [ADDR_WIDTH-1:0]   m1_address,
   input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
   output logic [DATA_WIDTH-1:0]   m1_readdata,
   output logic                    m1_waitrequest,
   output logic                    m1_readdatavalid,
   output logic                    s_read,
   output logic [ADDR_WIDTH-1:0]   s_address,
   output logic [DATA_WIDTH/8-1:0] s_byteenable,
   input  logic [DATA_WIDTH-1:0]   s_readdata,
   input  logic                    s_waitrequest,
   input  logic                    s_readdatavalid
);

   localparam int unsigned PTR_WIDTH    = $clog2(MAX_PENDING);
   localparam int unsigned CNT_WIDTH    = PTR_WIDTH + 1;
   localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

   logic                    lock_q;
   logic                    lock_id_q;
   logic [STARVE_WIDTH-1:0] starve_cnt_q;
   logic [MAX_PENDING-1:0]  tag_q;
   logic [PTR_WIDTH-1:0]    wr_ptr_q;
   logic [PTR_WIDTH-1:0]    rd_ptr_q;
   logic [CNT_WIDTH-1:0]    count_q;

   logic grant_valid;
   logic grant_id;
   logic grant_read;
   logic lock_read;
   logic starve_hit;
   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic pop;
   logic head_tag;

   assign starve_hit = (starve_cnt_q == STARVE_WIDTH'(STARVE_LIMIT));
   assign fifo_full  = (count_q == CNT_WIDTH'(MAX_PENDING));
   assign fifo_empty = (count_q == '0);

   // A stalled request keeps its grant until accepted, so address and byteenable
   // stay stable at the slave even if the other master starts requesting.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (lock_q) begin
         grant_valid = 1'b1;
         grant_id    = lock_id_q;
      end else if (m1_read && (!m0_read || starve_hit)) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end else if (m0_read) begin
         grant_valid = 1'b1;
      end
   end

   assign grant_read = grant_valid && (grant_id ? m1_read : m0_read);
   assign lock_read  = lock_id_q ? m1_read : m0_read;

   // Full blocks issue even when a pop happens in the same cycle; keeps the
   // response path out of the request path.
   assign s_read       = grant_read && !fifo_full && !reset;
   assign s_address    = (grant_valid && grant_id) ? m1_address : m0_address;
   assign s_byteenable = (grant_valid && grant_id) ? m1_byteenable : m0_byteenable;
   assign accept       = s_read && !s_waitrequest;

   assign m0_waitrequest = reset || !grant_valid || grant_id || fifo_full || s_waitrequest;
   assign m1_waitrequest = reset || !grant_valid || !grant_id || fifo_full || s_waitrequest;

   // Responses with no outstanding tag (e.g. after a mid-flight reset) are dropped.
   assign pop              = s_readdatavalid && !fifo_empty && !reset;
   assign head_tag         = tag_q[rd_ptr_q];
   assign m0_readdatavalid = pop && !head_tag;
   assign m1_readdatavalid = pop && head_tag;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q       <= 1'b0;
         lock_id_q    <= 1'b0;
         starve_cnt_q <= '0;
         tag_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         if (accept) begin
            tag_q[wr_ptr_q] <= grant_id;
            wr_ptr_q        <= wr_ptr_q + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + CNT_WIDTH'(1);
            2'b01:   count_q <= count_q - CNT_WIDTH'(1);
            default: count_q <= count_q;
         endcase

         if (accept) begin
            lock_q <= 1'b0;
         end else if (s_read && s_waitrequest) begin
            lock_q    <= 1'b1;
            lock_id_q <= grant_id;
         end else if (lock_q && !lock_read) begin
            lock_q <= 1'b0;
         end

         if (!m1_read || (accept && grant_id)) begin
            starve_cnt_q <= '0;
         end else if (accept && !grant_id && !starve_hit) begin
            starve_cnt_q <= starve_cnt_q + STARVE_WIDTH'(1);
         end
      end
   end

   // Simulation-only protocol checks; synthesis ignores immediate assertions.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(lock_q && !lock_read))
            else $error("vga_mem_read_arbiter: master %0d dropped read while stalled", lock_id_q);
         assert (!(s_readdatavalid && fifo_empty))
            else $error("vga_mem_read_arbiter: readdatavalid with no outstanding read");
      end
   end

endmodule

// File: tb/tb_vga_mem_read_arbiter.sv
// tb_vga_mem_read_arbiter
//   Directed bench for vga_mem_read_arbiter. A behavioural memory returns
//   MEM_OFF + address after a configurable latency; one task per scenario.
module tb_vga_mem_read_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned MP = 4;
   localparam int unsigned SL = 4;
   localparam logic [DW-1:0] MEM_OFF = 32'hA000_0000;

   logic          clk;
   logic          reset;
   logic          m0_read;
   logic [AW-1:0] m0_address;
   logic [BW-1:0] m0_byteenable;
   logic [DW-1:0] m0_readdata;
   logic          m0_waitrequest;
   logic          m0_readdatavalid;
   logic          m1_read;
   logic [AW-1:0] m1_address;
   logic [BW-1:0] m1_byteenable;
   logic [DW-1:0] m1_readdata;
   logic          m1_waitrequest;
   logic          m1_readdatavalid;
   logic          s_read;
   logic [AW-1:0] s_address;
   logic [BW-1:0] s_byteenable;
   logic [DW-1:0] s_readdata;
   logic          s_waitrequest;
   logic          s_readdatavalid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } req_t;

   req_t          mem_q[$];
   logic          acc_log[$];
   logic [DW-1:0] m0_got[$];
   logic [DW-1:0] m1_got[$];
   int            cyc = 0;
   int            mem_lat = 6;
   bit            mem_hold = 1'b0;
   bit            force_rdv = 1'b0;

   vga_mem_read_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MAX_PENDING (MP),
      .STARVE_LIMIT(SL)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .m0_read         (m0_read),
      .m0_address      (m0_address),
      .m0_byteenable   (m0_byteenable),
      .m0_readdata     (m0_readdata),
      .m0_waitrequest  (m0_waitrequest),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_read         (m1_read),
      .m1_address      (m1_address),
      .m1_byteenable   (m1_byteenable),
      .m1_readdata     (m1_readdata),
      .m1_waitrequest  (m1_waitrequest),
      .m1_readdatavalid(m1_readdatavalid),
      .s_read          (s_read),
      .s_address       (s_address),
      .s_byteenable    (s_byteenable),
      .s_readdata      (s_readdata),
      .s_waitrequest   (s_waitrequest),
      .s_readdatavalid (s_readdatavalid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] exp_data(input int a);
      return MEM_OFF + DW'(a);
   endfunction

   // Inputs change at posedge+1, the memory answers at posedge+2, observation at negedge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory response side.
   initial begin : mem_model
      req_t r;
      s_readdatavalid = 1'b0;
      s_readdata      = '0;
      forever begin
         @(posedge clk);
         #2;
         s_readdatavalid = 1'b0;
         s_readdata      = '0;
         if (reset) mem_q.delete();
         if (force_rdv) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 32'hDEAD_BEEF;
         end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r               = mem_q.pop_front();
            s_readdatavalid = 1'b1;
            s_readdata      = MEM_OFF + DW'(r.addr);
         end
      end
   end

   // Observer: logs accepted requests and delivered responses.
   initial begin : monitor
      req_t r;
      forever begin
         @(negedge clk);
         if (s_read && !s_waitrequest) begin
            r.addr = s_address;
            r.due  = cyc + mem_lat;
            mem_q.push_back(r);
            acc_log.push_back(!m1_waitrequest);
         end
         if (m0_readdatavalid) m0_got.push_back(m0_readdata);
         if (m1_readdatavalid) m1_got.push_back(m1_readdata);
         cyc++;
      end
   end

   task automatic clear_logs();
      acc_log.delete();
      m0_got.delete();
      m1_got.delete();
   endtask

   task automatic drive_m0(input logic [AW-1:0] base, input int n, input int budget,
                           output bit ok);
      int  i = 0;
      int  c = 0;
      bit  acc;
      while (i < n && c < budget) begin
         m0_read    = 1'b1;
         m0_address = base + AW'(i);
         @(negedge clk);
         acc = !m0_waitrequest;
         step();
         c++;
         if (acc) i++;
      end
      m0_read = 1'b0;
      ok = (i == n);
   endtask

   // mode 0: back-to-back; mode 1: idle gaps of 2-3 cycles between reads (~30% duty).
   task automatic drive_m1(input logic [AW-1:0] base, input int n, input int mode,
                           input int budget, output bit ok);
      int  i = 0;
      int  c = 0;
      bit  acc;
      while (i < n && c < budget) begin
         m1_read    = 1'b1;
         m1_address = base + AW'(i);
         @(negedge clk);
         acc = !m1_waitrequest;
         step();
         c++;
         if (acc) begin
            i++;
            if (mode != 0 && i < n) begin
               m1_read = 1'b0;
               repeat ((i % 3 == 0) ? 2 : 3) begin
                  step();
                  c++;
               end
            end
         end
      end
      m1_read = 1'b0;
      ok = (i == n);
   endtask

   task automatic wait_resp(input int n0, input int n1, input int budget, output bit ok);
      int c = 0;
      while ((m0_got.size() < n0 || m1_got.size() < n1) && c < budget) begin
         step();
         c++;
      end
      ok = (m0_got.size() >= n0 && m1_got.size() >= n1);
      // Extra cycles so spurious responses show up in the counts.
      repeat (mem_lat + 4) step();
   endtask

   task automatic test_reset();
      m0_read    = 1'b1;
      m0_address = 16'h0001;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0) begin
         errors++; $display("FAIL reset_s_read: got %b want 0", s_read);
      end
      checks++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL reset_waitreq: got %b%b want 11", m0_waitrequest, m1_waitrequest);
      end
      checks++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid);
      end
      step();
      reset   = 1'b0;
      m0_read = 1'b0;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_reset: s_read=%b wr=%b%b want 0 11", s_read,
                  m0_waitrequest, m1_waitrequest);
      end
      step();
   endtask

   task automatic test_m0_stream();
      bit ok_d, ok_r;
      mem_lat = 6;
      clear_logs();
      drive_m0(16'h0000, 24, 1000, ok_d);
      wait_resp(24, 0, 1000, ok_r);
      checks++;
      if (!ok_d || !ok_r) begin
         errors++; $display("FAIL m0_stream_done: issue=%b resp=%b want 11", ok_d, ok_r);
      end
      checks++;
      if (m0_got.size() != 24) begin
         errors++; $display("FAIL m0_stream_count: got %0d want 24", m0_got.size());
      end
      for (int i = 0; i < m0_got.size() && i < 24; i++) begin
         checks++;
         if (m0_got[i] !== exp_data(i)) begin
            errors++;
            $display("FAIL m0_stream_data[%0d]: got %h want %h", i, m0_got[i], exp_data(i));
         end
      end
      checks++;
      if (m1_got.size() != 0) begin
         errors++; $display("FAIL m0_stream_m1_rdv: got %0d want 0", m1_got.size());
      end
   endtask

   task automatic test_starvation();
      bit ok0, ok1, ok_r;
      mem_lat = 2;
      clear_logs();
      fork
         drive_m0(16'h0020, 20, 1000, ok0);
         drive_m1(16'h0120, 5, 0, 1000, ok1);
      join
      wait_resp(20, 5, 1000, ok_r);
      checks++;
      if (!ok0 || !ok1 || !ok_r) begin
         errors++;
         $display("FAIL starve_done: m0=%b m1=%b resp=%b want 111", ok0, ok1, ok_r);
      end
      checks++;
      if (acc_log.size() != 25) begin
         errors++; $display("FAIL starve_accepts: got %0d want 25", acc_log.size());
      end
      for (int k = 0; k < acc_log.size() && k < 25; k++) begin
         checks++;
         if (acc_log[k] !== ((k % 5) == 4)) begin
            errors++;
            $display("FAIL starve_order[%0d]: got m%0d want m%0d", k, acc_log[k], (k % 5) == 4);
         end
      end
      for (int i = 0; i < m0_got.size() && i < 20; i++) begin
         checks++;
         if (m0_got[i] !== exp_data(32'h20 + i)) begin
            errors++;
            $display("FAIL starve_m0_data[%0d]: got %h want %h", i, m0_got[i],
                     exp_data(32'h20 + i));
         end
      end
      for (int i = 0; i < m1_got.size() && i < 5; i++) begin
         checks++;
         if (m1_got[i] !== exp_data(32'h120 + i)) begin
            errors++;
            $display("FAIL starve_m1_data[%0d]: got %h want %h", i, m1_got[i],
                     exp_data(32'h120 + i));
         end
      end
      checks++;
      if (m0_got.size() != 20 || m1_got.size() != 5) begin
         errors++;
         $display("FAIL starve_resp_count: got %0d/%0d want 20/5", m0_got.size(), m1_got.size());
      end
   endtask

   task automatic test_lock();
      bit ok_r;
      mem_lat = 2;
      clear_logs();
      s_waitrequest = 1'b1;
      m1_read       = 1'b1;
      m1_address    = 16'h0155;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b1 || s_address !== 16'h0155 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL lock_first: s_read=%b addr=%h m1_wr=%b want 1 0155 1", s_read,
                  s_address, m1_waitrequest);
      end
      step();
      m0_read    = 1'b1;
      m0_address = 16'h0055;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (s_address !== 16'h0155 || s_byteenable !== 4'h3 || m0_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold: addr=%h be=%h m0_wr=%b want 0155 3 1", s_address,
                     s_byteenable, m0_waitrequest);
         end
         step();
      end
      s_waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || s_address !== 16'h0155) begin
         errors++;
         $display("FAIL lock_release: wr=%b%b addr=%h want m0=1 m1=0 0155", m0_waitrequest,
                  m1_waitrequest, s_address);
      end
      step();
      m1_read = 1'b0;
      @(negedge clk);
      checks++;
      if (m0_waitrequest !== 1'b0 || s_address !== 16'h0055) begin
         errors++;
         $display("FAIL lock_m0_next: m0_wr=%b addr=%h want 0 0055", m0_waitrequest, s_address);
      end
      step();
      m0_read = 1'b0;
      wait_resp(1, 1, 200, ok_r);
      checks++;
      if (!ok_r || m1_got[0] !== exp_data(32'h155) || m0_got[0] !== exp_data(32'h55)) begin
         errors++;
         $display("FAIL lock_data: m0=%h m1=%h want %h %h", m0_got[0], m1_got[0],
                  exp_data(32'h55), exp_data(32'h155));
      end
   endtask

   task automatic test_full();
      bit ok_d, ok_1, ok_r;
      mem_lat  = 1;
      mem_hold = 1'b1;
      clear_logs();
      drive_m0(16'h0040, 4, 200, ok_d);
      checks++;
      if (!ok_d) begin
         errors++; $display("FAIL full_fill: got %b want 1", ok_d);
      end
      m0_read    = 1'b1;
      m0_address = 16'h0044;
      m1_read    = 1'b1;
      m1_address = 16'h0144;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: s_read=%b wr=%b%b want 0 11", s_read, m0_waitrequest,
                     m1_waitrequest);
         end
         step();
      end
      mem_hold = 1'b0;
      @(negedge clk);
      checks++;
      if (m0_readdatavalid !== 1'b1 || s_read !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_cycle: rdv=%b s_read=%b want 1 0", m0_readdatavalid, s_read);
      end
      step();
      @(negedge clk);
      checks++;
      if (s_read !== 1'b1 || m0_waitrequest !== 1'b0 || s_address !== 16'h0044) begin
         errors++;
         $display("FAIL full_resume: s_read=%b m0_wr=%b addr=%h want 1 0 0044", s_read,
                  m0_waitrequest, s_address);
      end
      step();
      m0_read = 1'b0;
      drive_m1(16'h0144, 1, 0, 200, ok_1);
      wait_resp(5, 1, 300, ok_r);
      checks++;
      if (!ok_1 || !ok_r || m0_got.size() != 5 || m1_got.size() != 1) begin
         errors++;
         $display("FAIL full_counts: got %0d/%0d want 5/1", m0_got.size(), m1_got.size());
      end
      checks++;
      if (m0_got[4] !== exp_data(32'h44) || m1_got[0] !== exp_data(32'h144)) begin
         errors++;
         $display("FAIL full_data: m0=%h m1=%h want %h %h", m0_got[4], m1_got[0],
                  exp_data(32'h44), exp_data(32'h144));
      end
   endtask

   task automatic test_reset_mid();
      bit ok_1, ok_d, ok_r;
      mem_lat  = 2;
      mem_hold = 1'b1;
      clear_logs();
      drive_m1(16'h0180, 3, 0, 200, ok_1);
      reset      = 1'b1;
      force_rdv  = 1'b1;
      m0_read    = 1'b1;
      m0_address = 16'h0060;
      @(negedge clk);
      checks++;
      if (!ok_1 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_drop: issued=%b rdv=%b%b want 1 00", ok_1, m0_readdatavalid,
                  m1_readdatavalid);
      end
      checks++;
      if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_outputs: s_read=%b wr=%b%b want 0 11", s_read, m0_waitrequest,
                  m1_waitrequest);
      end
      step();
      reset     = 1'b0;
      force_rdv = 1'b0;
      mem_hold  = 1'b0;
      m0_read   = 1'b0;
      step();
      clear_logs();
      drive_m0(16'h0060, 1, 200, ok_d);
      wait_resp(1, 0, 200, ok_r);
      checks++;
      if (!ok_d || !ok_r || m0_got.size() != 1 || m1_got.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_after: got %0d/%0d want 1/0", m0_got.size(), m1_got.size());
      end
      checks++;
      if (m0_got[0] !== exp_data(32'h60)) begin
         errors++;
         $display("FAIL rst_mid_data: got %h want %h", m0_got[0], exp_data(32'h60));
      end
   endtask

   task automatic test_mixed();
      bit ok0, ok1, ok_r;
      mem_lat = 3;
      clear_logs();
      fork
         drive_m0(16'h0200, 32, 3000, ok0);
         drive_m1(16'h0300, 10, 1, 3000, ok1);
      join
      wait_resp(32, 10, 2000, ok_r);
      checks++;
      if (!ok0 || !ok1 || !ok_r || m0_got.size() != 32 || m1_got.size() != 10) begin
         errors++;
         $display("FAIL mixed_counts: got %0d/%0d want 32/10", m0_got.size(), m1_got.size());
      end
      for (int i = 0; i < m0_got.size() && i < 32; i++) begin
         checks++;
         if (m0_got[i] !== exp_data(32'h200 + i)) begin
            errors++;
            $display("FAIL mixed_m0[%0d]: got %h want %h", i, m0_got[i], exp_data(32'h200 + i));
         end
      end
      for (int i = 0; i < m1_got.size() && i < 10; i++) begin
         checks++;
         if (m1_got[i] !== exp_data(32'h300 + i)) begin
            errors++;
            $display("FAIL mixed_m1[%0d]: got %h want %h", i, m1_got[i], exp_data(32'h300 + i));
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      m0_read       = 1'b0;
      m0_address    = '0;
      m0_byteenable = 4'hF;
      m1_read       = 1'b0;
      m1_address    = '0;
      m1_byteenable = 4'h3;
      s_waitrequest = 1'b0;
      step();
      test_reset();
      test_m0_stream();
      test_starvation();
      test_lock();
      test_full();
      test_reset_mid();
      test_mixed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vga_mem_read_arbiter.md
Name: vga_mem_read_arbiter

Overview:
- Shares one Avalon-MM read-only memory port between two read masters.
- Master 0 is the VGA frame buffer stream and has high priority. Master 1 is a secondary reader (CPU or blitter).
- Supports pipelined reads with variable latency. Returning data is routed to the master that issued the read, in issue order.
- Bounded-starvation arbitration: master 1 always makes progress while master 0 is streaming a frame.

Parameters:
- ADDR_WIDTH, MM_MEM_ADDR_WIDTH, address width of all MM interfaces.
- DATA_WIDTH, MM_MEM_DATA_WIDTH, data width of all MM interfaces (multiple of 8).
- MAX_PENDING, 8, maximum outstanding reads on the slave side; depth of the tag FIFO (power of 2, ≥2).
- STARVE_LIMIT, 16, maximum consecutive accepted m0 reads while m1 is requesting (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_read  in  1  master 0 read request
- m0_address  in  ADDR_WIDTH  master 0 address
- m0_byteenable  in  DATA_WIDTH/8  master 0 byte enables
- m0_readdata  out  DATA_WIDTH  read data (shared bus)
- m0_waitrequest  out  1  master 0 stall
- m0_readdatavalid  out  1  read data valid for master 0
- m1_read, m1_address, m1_byteenable, m1_readdata, m1_waitrequest, m1_readdatavalid: same as m0_*, for master 1
- s_read  out  1  read to memory
- s_address  out  ADDR_WIDTH  address to memory
- s_byteenable  out  DATA_WIDTH/8  byte enables to memory
- s_readdata  in  DATA_WIDTH  memory read data
- s_waitrequest  in  1  memory stall
- s_readdatavalid  in  1  memory read data valid

Behaviour:

Outputs and reset
- During reset and after it: s_read=0, lock cleared, tag FIFO empty, starve counter=0.
- m0_readdatavalid=0 and m1_readdatavalid=0; both waitrequests=1 while reset is high.
- Reset mid-operation discards all pending tags. Any readdatavalid arriving later with the FIFO empty is dropped (never forwarded) and raises a simulation-only $error.

Grant selection (combinational, per cycle)
- If lock is set: grant = locked master.
- Else if m1_read && (!m0_read || starve_cnt == STARVE_LIMIT): grant = 1.
- Else if m0_read: grant = 0.
- Else: no grant.

Slave side
- s_read = granted master's read && !fifo_full && !reset.
- s_address and s_byteenable = granted master's signals (m0's when no grant).

Waitrequest
- mX_waitrequest = reset || grant != X || fifo_full || s_waitrequest.
- Zero added latency: an accepted request reaches the slave in the same cycle.

Accept and lock
- Accept = s_read && !s_waitrequest. On accept, push the grant ID into the tag FIFO.
- If s_read && s_waitrequest: set lock to the granted master. This holds the request stable per Avalon rules.
- Clear lock on accept, or if the locked master drops read. Dropping read while stalled is a protocol violation; raise a simulation $error.

Starvation counter
- Increment on an m0 accept while m1_read=1.
- Clear on an m1 accept, or in any cycle with m1_read=0.
- Saturates at STARVE_LIMIT.

Response routing
- On s_readdatavalid: pop the FIFO head and assert readdatavalid for that master only, same cycle (combinational).
- m0_readdata = m1_readdata = s_readdata.

FIFO
- Full = MAX_PENDING outstanding. When full, no issue that cycle, even if a pop occurs in the same cycle. This is conservative and keeps the timing path short.
- Simultaneous push and pop when not full: count unchanged, both operations performed.
- Pointers wrap modulo MAX_PENDING.

Test Plan:
1. Memory sim (latency 6, 4 pending), m0 alone reads addresses 0..23 back-to-back -> m0 gets 24 readdatavalid pulses, in order, with data = MEM_INIT_OFFSET+i; m1_readdatavalid never asserts.
2. m0 and m1 request in the same cycle, m0 continuous, STARVE_LIMIT=4 -> accept pattern is 4×m0, 1×m1, repeating. Each m1 response arrives on m1_readdatavalid only, interleaved correctly.
3. s_waitrequest held high 3 cycles while m1 is granted, then m0 asserts read -> grant stays on m1 (locked), s_address stable; m1 accepted first, m0 next cycle.
4. Issue reads until MAX_PENDING outstanding, with responses delayed -> both waitrequests high and s_read=0 until the first s_readdatavalid. Issue resumes the following cycle.
5. Assert reset for 1 cycle with 3 reads pending -> outputs return to reset values. Late s_readdatavalid pulses are not forwarded to either master. The next m0 read completes normally.
6. Full VGA stream frame through arbiter with random m1 traffic (30% duty) -> stream delivers all words plus the endofpacket trailer without error. m1 receives every response with correct data.
